// File: rtl/spatial_encoder_sequencer.sv
// Feeds one multi-channel sample into the spatial encoder. Each channel gets one memory
// read and one din handshake, and the next sample is held off until the encoder output has been taken.
module spatial_encoder_sequencer #(
  parameter int NUM_CHANNEL      = 32,
  parameter int FEATURE_WIDTH    = 5,
  parameter int NUM_LEVELS       = 21,
  parameter int SAMPLE_CNT_WIDTH = 16,
  localparam int IM_AW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int PM_AW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sample_valid,
  output logic                                 sample_ready,
  input  logic [NUM_CHANNEL*FEATURE_WIDTH-1:0] sample_features,
  output logic                                 mem_rd_en,
  output logic [IM_AW-1:0]                     im_addr,
  output logic [PM_AW-1:0]                     projm_addr,
  output logic                                 enc_din_valid,
  input  logic                                 enc_din_ready,
  input  logic                                 enc_hvout_valid,
  input  logic                                 enc_hvout_ready,
  output logic                                 busy,
  output logic [SAMPLE_CNT_WIDTH-1:0]          sample_count,
  output logic [1:0]                           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // drops, and its payload never changes, until that transfer.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_ISSUE    = 2'd2,
    S_WAIT_OUT = 2'd3
  } state_t;

  localparam logic [FEATURE_WIDTH-1:0] MAX_LVL = FEATURE_WIDTH'(NUM_LEVELS - 1);
  localparam logic [PM_AW-1:0]         LAST_CH = PM_AW'(NUM_CHANNEL - 1);

  state_t                               state_q, state_d;
  logic [PM_AW-1:0]                     ch_q, ch_d;
  logic [NUM_CHANNEL*FEATURE_WIDTH-1:0] feat_q, feat_d;
  logic [IM_AW-1:0]                     im_addr_q, im_addr_d;
  logic [PM_AW-1:0]                     projm_addr_q, projm_addr_d;
  logic [SAMPLE_CNT_WIDTH-1:0]          cnt_q, cnt_d;

  logic [FEATURE_WIDTH-1:0] feat_arr [NUM_CHANNEL];
  logic [PM_AW-1:0]         rd_ch;
  logic [FEATURE_WIDTH-1:0] rd_feat;
  logic [FEATURE_WIDTH-1:0] rd_sat;

  for (genvar i = 0; i < NUM_CHANNEL; i++) begin : g_feat
    assign feat_arr[i] = feat_q[i*FEATURE_WIDTH +: FEATURE_WIDTH];
  end

  assign rd_feat = feat_arr[rd_ch];
  assign rd_sat  = (rd_feat > MAX_LVL) ? MAX_LVL : rd_feat;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    feat_d        = feat_q;
    cnt_d         = cnt_q;
    mem_rd_en     = 1'b0;
    enc_din_valid = 1'b0;
    rd_ch         = ch_q;
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          feat_d  = sample_features;
          ch_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        enc_din_valid = 1'b1;
        if (enc_din_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = S_WAIT_OUT;
          end else begin
            // Prefetch the next channel in the fire cycle so channels stream at one per clock.
            mem_rd_en = 1'b1;
            rd_ch     = ch_q + PM_AW'(1);
            ch_d      = ch_q + PM_AW'(1);
          end
        end
      end
      S_WAIT_OUT: begin
        if (enc_hvout_valid && enc_hvout_ready) begin
          cnt_d   = cnt_q + SAMPLE_CNT_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The addresses stay at the last value read so that a stalled memory sees a stable request.
  assign im_addr      = mem_rd_en ? IM_AW'(rd_sat) : im_addr_q;
  assign projm_addr   = mem_rd_en ? rd_ch : projm_addr_q;
  assign im_addr_d    = im_addr;
  assign projm_addr_d = projm_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      feat_q       <= '0;
      im_addr_q    <= '0;
      projm_addr_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      feat_q       <= feat_d;
      im_addr_q    <= im_addr_d;
      projm_addr_q <= projm_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sample_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign sample_count = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/spatial_encoder_sequencer.md
Name: spatial_encoder_sequencer

Overview:
- Control block that sequences one multi-channel sample into the spatial encoder.
- Latches a packed vector of quantized channel features and walks the channels in order.
- For each channel it reads the item memory (level hypervector) and the projection memory (channel hypervector), then presents exactly one din handshake per channel to the encoder.
- Holds off the next sample until the encoder's output hypervector has been consumed. Sits between the sample front-end and the spatial encoder and its two hypervector memories.

Parameters:
NUM_CHANNEL, 32, channels per sample; must equal the encoder's num_channel
FEATURE_WIDTH, 5, bits per quantized channel feature
NUM_LEVELS, 21, number of item-memory levels (im_addr range 0..NUM_LEVELS-1)
SAMPLE_CNT_WIDTH, 16, width of the completed-sample counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
sample_valid  input  1  sample offered
sample_ready  output  1  sequencer can accept a sample
sample_features  input  NUM_CHANNEL*FEATURE_WIDTH  channel i at bits [i*FEATURE_WIDTH +: FEATURE_WIDTH]
mem_rd_en  output  1  read strobe to item and projection memories
im_addr  output  ceilLog2(NUM_LEVELS)  item-memory level address
projm_addr  output  ceilLog2(NUM_CHANNEL)  projection-memory channel address
enc_din_valid  output  1  to encoder din_valid
enc_din_ready  input  1  from encoder din_ready
enc_hvout_valid  input  1  encoder output valid (monitored)
enc_hvout_ready  input  1  consumer ready on encoder output (monitored)
busy  output  1  high in every state except IDLE
sample_count  output  SAMPLE_CNT_WIDTH  number of completed samples

Behaviour:
- Reset (rst=0, asynchronous; takes effect without a clock edge):
  - state=IDLE, channel index=0, sample_count=0.
  - Outputs: mem_rd_en=0, enc_din_valid=0, busy=0, sample_ready=1.
  - im_addr and projm_addr reset to 0.
  - Reset mid-sample abandons the sample. The system must reset the encoder in the same window; no recovery handshake is performed.
- Memory contract:
  - 1-cycle read latency.
  - Read data holds its last value while mem_rd_en=0.
- States: IDLE, FETCH, ISSUE, WAIT_OUT.
- IDLE:
  - sample_ready=1.
  - On sample_valid: latch sample_features, set ch=0, go to FETCH.
- FETCH (exactly one cycle):
  - mem_rd_en=1, projm_addr=ch, im_addr=sat(feature[ch]).
  - Next state ISSUE.
- ISSUE:
  - enc_din_valid=1; held stable until enc_din_valid && enc_din_ready (fire).
  - On fire with ch<NUM_CHANNEL-1: in the same cycle drive mem_rd_en=1 with the addresses for ch+1, set ch<=ch+1, stay in ISSUE. This gives back-to-back throughput of 1 channel/cycle.
  - On fire with ch==NUM_CHANNEL-1: mem_rd_en=0, go to WAIT_OUT.
  - No fire: mem_rd_en=0; addresses and ch hold.
- WAIT_OUT:
  - enc_din_valid=0.
  - On enc_hvout_valid && enc_hvout_ready: sample_count<=sample_count+1 (wraps modulo 2^SAMPLE_CNT_WIDTH), go to IDLE.
- Saturation: sat(f) = (f > NUM_LEVELS-1) ? NUM_LEVELS-1 : f. Compare at FEATURE_WIDTH bits, then truncate to the im_addr width.
- Exactly NUM_CHANNEL din fires per accepted sample; never a fire outside ISSUE.
- Latency, with enc_din_ready held high and sample fire in cycle t:
  - FETCH at t+1.
  - Channel k din fire at t+2+k; last fire at t+1+NUM_CHANNEL.
  - Encoder hvout_valid at t+NUM_CHANNEL+4.
  - Earliest next sample_ready is one cycle after the hvout fire.
- Simultaneous events:
  - sample_valid is ignored outside IDLE; the features register does not change.
  - An hvout fire seen in ISSUE (protocol error) is ignored.

Test Plan:
- NUM_CHANNEL=4, features {3,0,7,1}, enc_din_ready=1 -> im_addr sequence 3,0,7,1 and projm_addr 0,1,2,3 on consecutive mem_rd_en cycles; 4 din fires at t+2..t+5; busy=1 throughout.
- enc_din_ready low for 3 cycles during ch=2 -> enc_din_valid held; im_addr=7 and projm_addr=2 stable; mem_rd_en=0; exactly 4 fires total.
- NUM_LEVELS=21, FEATURE_WIDTH=5, feature 31 -> im_addr=20; feature 20 -> im_addr=20.
- Hold enc_hvout_ready=0 for 5 cycles in WAIT_OUT -> state stays in WAIT_OUT, sample_ready=0, sample_count unchanged; one ready cycle -> count +1, sample_ready=1 the next cycle.
- Assert rst=0 asynchronously mid-ISSUE at ch=2 -> outputs return to reset values immediately; the next sample restarts at projm_addr=0.
- SAMPLE_CNT_WIDTH=2, run 5 samples -> sample_count sequence 1,2,3,0,1.
